// File: rtl/intr_prio_ctrl.sv
// +--------------------------------------------------------------------------+
// | intr_prio_ctrl                                                           |
// | Four-source vectored priority interrupt controller with nesting.         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module intr_prio_ctrl #(
  parameter int          PRIO_W   = 4,
  parameter int unsigned RST_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        irq,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [PRIO_W-1:0] cfg_prio,
  input  logic              iack,
  input  logic              eoi,
  output logic              intr,
  output logic [1:0]        vec,
  output logic [3:0]        iack_clr,
  output logic [3:0]        pending,
  output logic [3:0]        isr,
  output logic [PRIO_W-1:0] cur_lvl
);

  localparam logic [PRIO_W-1:0] c_rst_prio = PRIO_W'(RST_PRIO);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GRANT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_latch;
  logic [1:0]        r_win_id;
  logic [3:0]        r_irq_q;
  logic [3:0]        r_pending;
  logic [3:0]        r_isr;
  logic [PRIO_W-1:0] r_prio [4];

  logic [3:0]        w_prio_nz;
  logic [3:0]        w_edge;
  logic [3:0]        w_grant_oh;
  logic [PRIO_W-1:0] w_cur_lvl;
  logic              w_win_found;
  logic [1:0]        w_win_id;
  logic [PRIO_W-1:0] w_win_prio;
  logic              w_eligible;
  logic              w_eoi_found;
  logic [1:0]        w_eoi_id;
  logic [PRIO_W-1:0] w_eoi_prio;
  logic [3:0]        w_eoi_clr;

  for (genvar g = 0; g < 4; g++) begin : g_prio_nz
    assign w_prio_nz[g] = |r_prio[g];
  end

  assign w_edge     = irq & ~r_irq_q;
  assign w_grant_oh = (r_state == ST_GRANT) ? (4'b0001 << r_win_id) : 4'b0000;

  // Highest in-service level; follows priority rewrites without delay.
  always_comb begin
    w_cur_lvl = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_isr[i] && (r_prio[i] > w_cur_lvl)) begin
        w_cur_lvl = r_prio[i];
      end
    end
  end

  // Ascending scan with strict compare keeps the lower index on ties.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = 2'd0;
    w_win_prio  = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_pending[i] && w_prio_nz[i] && (r_prio[i] > w_win_prio)) begin
        w_win_found = 1'b1;
        w_win_id    = 2'(i);
        w_win_prio  = r_prio[i];
      end
    end
  end

  assign w_eligible = w_win_found && (w_win_prio > w_cur_lvl);

  // EOI target must still be found if its priority was rewritten to zero.
  always_comb begin
    w_eoi_found = 1'b0;
    w_eoi_id    = 2'd0;
    w_eoi_prio  = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_isr[i] && (!w_eoi_found || (r_prio[i] > w_eoi_prio))) begin
        w_eoi_found = 1'b1;
        w_eoi_id    = 2'(i);
        w_eoi_prio  = r_prio[i];
      end
    end
  end

  assign w_eoi_clr = (eoi && w_eoi_found) ? (4'b0001 << w_eoi_id) : 4'b0000;

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_eligible) begin
          w_state_nxt = ST_ASSERT;
          w_latch     = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (iack) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_win_id <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_win_id <= w_win_id;
      end
    end
  end

  // A grant clear overrides a same-cycle new edge on that source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_q   <= 4'b0000;
      r_pending <= 4'b0000;
      r_isr     <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_prio[i] <= c_rst_prio;
      end
    end else begin
      r_irq_q   <= irq;
      r_pending <= (r_pending | (w_edge & w_prio_nz)) & ~w_grant_oh;
      r_isr     <= (r_isr & ~w_eoi_clr) | w_grant_oh;
      if (cfg_we) begin
        r_prio[cfg_sel] <= cfg_prio;
      end
    end
  end

  assign intr     = (r_state == ST_ASSERT);
  assign vec      = r_win_id;
  assign iack_clr = w_grant_oh;
  assign pending  = r_pending;
  assign isr      = r_isr;
  assign cur_lvl  = w_cur_lvl;

endmodule

`default_nettype wire

// File: tb/tb_intr_prio_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_intr_prio_ctrl                                                        |
// | Directed plus random stimulus against a behavioural reference model.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_intr_prio_ctrl;

  localparam int c_prio_w = 4;

  logic                clk;
  logic                rst_n;
  logic [3:0]          irq;
  logic                cfg_we;
  logic [1:0]          cfg_sel;
  logic [c_prio_w-1:0] cfg_prio;
  logic                iack;
  logic                eoi;
  logic                intr;
  logic [1:0]          vec;
  logic [3:0]          iack_clr;
  logic [3:0]          pending;
  logic [3:0]          isr;
  logic [c_prio_w-1:0] cur_lvl;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int       m_prio [4];
  bit [3:0] m_pend;
  bit [3:0] m_isr;
  bit [3:0] m_irqq;
  bit       m_pres;
  bit       m_grant;
  int       m_vec;

  intr_prio_ctrl #(.PRIO_W(c_prio_w), .RST_PRIO(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq      (irq),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_prio (cfg_prio),
    .iack     (iack),
    .eoi      (eoi),
    .intr     (intr),
    .vec      (vec),
    .iack_clr (iack_clr),
    .pending  (pending),
    .isr      (isr),
    .cur_lvl  (cur_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_prio[i] = 0;
    m_pend  = '0;
    m_isr   = '0;
    m_irqq  = '0;
    m_pres  = 1'b0;
    m_grant = 1'b0;
    m_vec   = 0;
  endfunction

  function automatic int level_of(input bit [3:0] bits);
    int mx = 0;
    for (int i = 0; i < 4; i++) if (bits[i] && m_prio[i] > mx) mx = m_prio[i];
    return mx;
  endfunction

  // Largest priority among candidates, then the first index holding it; -1 if none.
  function automatic int pick(input bit [3:0] cand);
    int mx = -1;
    for (int i = 0; i < 4; i++) if (cand[i] && m_prio[i] > mx) mx = m_prio[i];
    for (int i = 0; i < 4; i++) if (cand[i] && m_prio[i] == mx) return i;
    return -1;
  endfunction

  task automatic check_all(input string tag);
    bit [3:0] oh;
    oh = m_grant ? (4'b0001 << m_vec) : 4'b0000;
    check_eq({tag, ".intr"}, 32'(intr), 32'(m_pres));
    if (m_pres) check_eq({tag, ".vec"}, 32'(vec), 32'(m_vec));
    check_eq({tag, ".iack_clr"}, 32'(iack_clr), 32'(oh));
    check_eq({tag, ".pending"}, 32'(pending), 32'(m_pend));
    check_eq({tag, ".isr"}, 32'(isr), 32'(m_isr));
    check_eq({tag, ".cur_lvl"}, 32'(cur_lvl), 32'(level_of(m_isr)));
  endtask

  // Called at a falling edge; drives one cycle, advances the model, checks after the rising edge.
  task automatic drive(input logic [3:0] t_irq, input bit t_we, input logic [1:0] t_sel,
                       input logic [3:0] t_prio, input bit t_iack, input bit t_eoi);
    bit [3:0] nz, gmask, emask, npend, nisr;
    int w, e;
    irq = t_irq; cfg_we = t_we; cfg_sel = t_sel; cfg_prio = t_prio; iack = t_iack; eoi = t_eoi;
    for (int i = 0; i < 4; i++) nz[i] = (m_prio[i] != 0);
    gmask = m_grant ? (4'b0001 << m_vec) : 4'b0000;
    w = pick(m_pend & nz);
    e = pick(m_isr);
    emask = (t_eoi && e >= 0) ? (4'b0001 << e) : 4'b0000;
    npend = (m_pend | (t_irq & ~m_irqq & nz)) & ~gmask;
    nisr  = (m_isr & ~emask) | gmask;
    if (m_grant) begin
      m_grant = 1'b0;
    end else if (m_pres) begin
      if (t_iack) begin
        m_pres  = 1'b0;
        m_grant = 1'b1;
      end
    end else if (w >= 0 && m_prio[w] > level_of(m_isr)) begin
      m_pres = 1'b1;
      m_vec  = w;
    end
    m_pend = npend;
    m_isr  = nisr;
    m_irqq = t_irq;
    if (t_we) m_prio[t_sel] = int'(t_prio);
    @(posedge clk);
    #1;
    check_all("cyc");
    @(negedge clk);
  endtask

  task automatic cyc(input logic [3:0] t_irq, input bit t_iack, input bit t_eoi);
    drive(t_irq, 1'b0, 2'd0, 4'd0, t_iack, t_eoi);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [3:0] p);
    drive(4'b0000, 1'b1, sel, p, 1'b0, 1'b0);
  endtask

  // Asserts reset a little after a falling edge and checks the immediate effect.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    irq = '0; cfg_we = 1'b0; iack = 1'b0; eoi = 1'b0;
    #1;
    check_eq({tag, ".intr"}, 32'(intr), 32'd0);
    check_eq({tag, ".pending"}, 32'(pending), 32'd0);
    check_eq({tag, ".isr"}, 32'(isr), 32'd0);
    check_eq({tag, ".iack_clr"}, 32'(iack_clr), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_eq({tag, ".iack_clr_hold"}, 32'(iack_clr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    irq = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_prio = '0; iack = 1'b0; eoi = 1'b0;
    #1;
    check_eq("rst.intr", 32'(intr), 32'd0);
    check_eq("rst.vec", 32'(vec), 32'd0);
    check_eq("rst.iack_clr", 32'(iack_clr), 32'd0);
    check_eq("rst.pending", 32'(pending), 32'd0);
    check_eq("rst.isr", 32'(isr), 32'd0);
    check_eq("rst.cur_lvl", 32'(cur_lvl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic grant of source 2
    cfg(2'd0, 4'd1); cfg(2'd1, 4'd2); cfg(2'd2, 4'd3); cfg(2'd3, 4'd4);
    cyc(4'b0100, 0, 0);
    check_eq("t1.pending", 32'(pending), 32'h4);
    check_eq("t1.intr_early", 32'(intr), 32'd0);
    cyc(4'b0000, 0, 0);
    check_eq("t1.intr", 32'(intr), 32'd1);
    check_eq("t1.vec", 32'(vec), 32'd2);
    cyc(4'b0000, 1, 0);
    check_eq("t1.iack_clr", 32'(iack_clr), 32'h4);
    check_eq("t1.intr_off", 32'(intr), 32'd0);
    cyc(4'b0000, 0, 0);
    check_eq("t1.isr", 32'(isr), 32'h4);
    check_eq("t1.cur_lvl", 32'(cur_lvl), 32'd3);
    check_eq("t1.iack_clr_off", 32'(iack_clr), 32'h0);

    // Lower priority blocked until EOI
    cyc(4'b0001, 0, 0);
    check_eq("t2.pending", 32'(pending), 32'h1);
    cyc(4'b0000, 0, 0);
    check_eq("t2.intr_blocked", 32'(intr), 32'd0);
    cyc(4'b0000, 0, 1);
    check_eq("t2.isr", 32'(isr), 32'h0);
    check_eq("t2.cur_lvl", 32'(cur_lvl), 32'd0);
    cyc(4'b0000, 0, 0);
    check_eq("t2.intr", 32'(intr), 32'd1);
    check_eq("t2.vec", 32'(vec), 32'd0);
    cyc(4'b0000, 1, 0); cyc(4'b0000, 0, 0); cyc(4'b0000, 0, 1);

    // Preemption by source 3 while source 2 in service
    cyc(4'b0100, 0, 0); cyc(4'b0000, 0, 0); cyc(4'b0000, 1, 0); cyc(4'b0000, 0, 0);
    cyc(4'b1000, 0, 0); cyc(4'b0000, 0, 0);
    check_eq("t3.intr", 32'(intr), 32'd1);
    check_eq("t3.vec", 32'(vec), 32'd3);
    cyc(4'b0000, 1, 0); cyc(4'b0000, 0, 0);
    check_eq("t3.isr", 32'(isr), 32'hc);
    check_eq("t3.cur_lvl", 32'(cur_lvl), 32'd4);
    cyc(4'b0000, 0, 1);
    check_eq("t3.isr_eoi", 32'(isr), 32'h4);
    check_eq("t3.cur_lvl_eoi", 32'(cur_lvl), 32'd3);
    cyc(4'b0000, 0, 1);

    // Equal priorities: tie to lower index, equal level never preempts
    cfg(2'd1, 4'd5); cfg(2'd2, 4'd5);
    cyc(4'b0110, 0, 0); cyc(4'b0000, 0, 0);
    check_eq("t4.vec", 32'(vec), 32'd1);
    cyc(4'b0000, 1, 0); cyc(4'b0000, 0, 0); cyc(4'b0000, 0, 0);
    check_eq("t4.intr_equal", 32'(intr), 32'd0);
    check_eq("t4.isr", 32'(isr), 32'h2);
    cyc(4'b0000, 0, 1); cyc(4'b0000, 0, 0);
    check_eq("t4.vec2", 32'(vec), 32'd2);
    check_eq("t4.intr2", 32'(intr), 32'd1);
    cyc(4'b0000, 1, 0); cyc(4'b0000, 0, 0); cyc(4'b0000, 0, 1);

    // Disabled source, then held level gives one pending only
    cfg(2'd0, 4'd0);
    cyc(4'b0001, 0, 0);
    check_eq("t5.pending_dis", 32'(pending), 32'h0);
    cyc(4'b0000, 0, 0);
    check_eq("t5.intr_dis", 32'(intr), 32'd0);
    cfg(2'd0, 4'd2);
    for (int k = 0; k < 12; k++) cyc(4'b0001, m_pres, 0);
    check_eq("t5.pending_held", 32'(pending), 32'h0);
    check_eq("t5.isr_held", 32'(isr), 32'h1);
    cyc(4'b0000, 0, 1);

    // Async reset during ASSERT
    cyc(4'b0010, 0, 0); cyc(4'b0000, 0, 0);
    check_eq("t6.intr", 32'(intr), 32'd1);
    check_eq("t6.vec", 32'(vec), 32'd1);
    async_reset("t6");
    cyc(4'b0010, 0, 0);
    check_eq("t6.prio_reset", 32'(pending), 32'h0);
    cyc(4'b0000, 0, 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [3:0] r_irq;
      r_irq = 4'($urandom) & 4'($urandom);
      if (k == 200) async_reset("rnd_rst");
      drive(r_irq, ($urandom_range(0, 9) == 0), 2'($urandom), 4'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
